jtcps1_tile_linebuf: RTL

- Double-buffered line buffer between one scroll-layer tile renderer and the video mixer.
- During line N the renderer writes line N+1 into the write bank, while the read bank streams line N out at pixel rate.
- The block generates the renderer start/line number, swaps banks at each line start, and refills the read bank with a transparent value behind the read pointer.

---
 rtl/jtcps1_tile_linebuf_pkg.sv | 21 ++
 rtl/jtcps1_linebuf_ram.sv | 26 ++
 rtl/jtcps1_tile_linebuf.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/jtcps1_tile_linebuf_pkg.sv
// Shared definitions for the CPS1 scroll-layer line buffer.
package jtcps1_tile_linebuf_pkg;

  localparam logic [7:0] FILL_DEF = 8'hFF;
  localparam int         HVIS_DEF = 384;

  // Countdown loaded at line start so render_done is ignored on L+1 and L+2.
  localparam logic [1:0] IGN_LOAD = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } render_state_e;

  // Line counter is 9 bits, so 511 wraps to 0 by width alone.
  function automatic logic [8:0] next_line(input logic [8:0] v);
    return v + 9'd1;
  endfunction

endpackage

// File: rtl/jtcps1_linebuf_ram.sv
// Dual-bank pixel RAM: port A takes renderer writes, port B reads and clears behind.
module jtcps1_linebuf_ram #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_re,
  input  logic [AW-1:0] b_raddr,
  input  logic          b_we,
  input  logic [AW-1:0] b_waddr,
  input  logic [DW-1:0] b_wdata,
  output logic [DW-1:0] b_q
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_data;
    if (b_we) mem[b_waddr] <= b_wdata;
    if (b_re) b_q <= mem[b_raddr];
  end

endmodule

// File: rtl/jtcps1_tile_linebuf.sv
// Double-buffered line buffer between a tile renderer and the video mixer.
//
// state        | meaning
// ST_IDLE      | no render outstanding for this line
// ST_START     | render requested, stale render_done still ignored
// ST_WAIT_DONE | render requested, waiting for render_done
module jtcps1_tile_linebuf
  import jtcps1_tile_linebuf_pkg::*;
#(
  parameter int            AW   = 9,
  parameter int            DW   = 8,
  parameter logic [DW-1:0] FILL = DW'(FILL_DEF),
  parameter int            HVIS = HVIS_DEF
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          pxl_cen,
  input  logic          hs,
  input  logic [8:0]    vdump,
  input  logic [8:0]    hdump,
  output logic [8:0]    render_v,
  output logic          render_start,
  input  logic          render_done,
  input  logic [AW-1:0] buf_addr,
  input  logic [DW-1:0] buf_data,
  input  logic          buf_wr,
  output logic [DW-1:0] pxl,
  output logic          overrun
);

  localparam logic [8:0] HVIS_L = 9'(HVIS);

  render_state_e state_q, state_d;
  logic [1:0]    ign_cnt_q, ign_cnt_d;
  logic          hs_q, hs_d;
  logic          wr_bank_q, wr_bank_d;
  logic [1:0]    valid_q, valid_d;
  logic          done_q, done_d;
  logic [8:0]    render_v_q, render_v_d;
  logic          overrun_q, overrun_d;
  logic          rd_ok_q, rd_ok_d;
  logic          clr_pend_q, clr_pend_d;
  logic [AW:0]   clr_addr_q, clr_addr_d;

  logic          line_start;
  logic          rd_bank;
  logic          in_vis;
  logic [DW-1:0] ram_q;

  assign line_start = hs & ~hs_q;
  assign rd_bank    = ~wr_bank_q;
  assign in_vis     = hdump < HVIS_L;

  always_comb begin
    state_d    = state_q;
    ign_cnt_d  = ign_cnt_q;
    hs_d       = hs;
    wr_bank_d  = wr_bank_q;
    valid_d    = valid_q;
    done_d     = done_q;
    render_v_d = render_v_q;
    overrun_d  = 1'b0;
    rd_ok_d    = rd_ok_q;
    clr_pend_d = 1'b0;
    clr_addr_d = clr_addr_q;

    case (state_q)
      ST_START: begin
        if (ign_cnt_q == 2'd0) state_d = ST_WAIT_DONE;
        else                   ign_cnt_d = ign_cnt_q - 2'd1;
      end
      ST_WAIT_DONE: begin
        if (render_done) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase

    // Line start overrides any acceptance in the same cycle: that render missed its line.
    if (line_start) begin
      wr_bank_d          = ~wr_bank_q;
      render_v_d         = next_line(vdump);
      state_d            = ST_START;
      ign_cnt_d          = IGN_LOAD;
      overrun_d          = (state_q != ST_IDLE);
      done_d             = 1'b0;
      valid_d[wr_bank_q] = done_q;
      valid_d[rd_bank]   = 1'b0;
    end

    if (pxl_cen) begin
      rd_ok_d    = in_vis & valid_q[rd_bank];
      clr_pend_d = in_vis;
      clr_addr_d = {rd_bank, hdump[AW-1:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ign_cnt_q  <= 2'd0;
      hs_q       <= 1'b0;
      wr_bank_q  <= 1'b0;
      valid_q    <= 2'b00;
      done_q     <= 1'b0;
      render_v_q <= 9'd0;
      overrun_q  <= 1'b0;
      rd_ok_q    <= 1'b0;
      clr_pend_q <= 1'b0;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      ign_cnt_q  <= ign_cnt_d;
      hs_q       <= hs_d;
      wr_bank_q  <= wr_bank_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      render_v_q <= render_v_d;
      overrun_q  <= overrun_d;
      rd_ok_q    <= rd_ok_d;
      clr_pend_q <= clr_pend_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  jtcps1_linebuf_ram #(.AW(AW + 1), .DW(DW)) u_ram (
    .clk     (clk),
    .a_we    (buf_wr),
    .a_addr  ({wr_bank_q, buf_addr}),
    .a_data  (buf_data),
    .b_re    (pxl_cen),
    .b_raddr ({rd_bank, hdump[AW-1:0]}),
    .b_we    (clr_pend_q),
    .b_waddr (clr_addr_q),
    .b_wdata (FILL),
    .b_q     (ram_q)
  );

  // RAM output only moves on pxl_cen, so pxl holds between pixels.
  assign pxl          = rd_ok_q ? ram_q : FILL;
  assign render_start = (state_q != ST_IDLE);
  assign render_v     = render_v_q;
  assign overrun      = overrun_q;

endmodule
